// File: rtl/counter.sv
// Free-running unsigned up-counter adding STEP per clock, synchronous active-high reset.
// Define COUNTER_SATURATE_EN to make the count stick at all-ones instead of wrapping.
module counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned STEP        = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Initialiser gives the reset value at power-up, before any reset edge.
    logic [WIDTH-1:0] count = RST_W;
    logic [WIDTH-1:0] count_next;

`ifdef COUNTER_SATURATE_EN
    logic [WIDTH:0] sum;

    // The extra MSB is the carry; once set, the count pins at all-ones.
    always_comb begin
        sum        = {1'b0, count} + {1'b0, STEP_W};
        count_next = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    end
`else
    always_comb begin
        count_next = count + STEP_W;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RST_W;
        end else begin
            count <= count_next;
        end
    end

    assign out = count;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: default instance and a WIDTH=8/STEP=3/RESET_VALUE=5 instance.
// Expectations follow the build: COUNTER_SATURATE_EN selects saturating values.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset_a = 1'b0;
    logic       reset_b = 1'b1;
    logic [7:0] out_a;
    logic [7:0] out_b;

    int checks = 0;
    int errors = 0;

    int q_a[$];
    int q_b[$];

    always #5 clk = ~clk;

    counter dut_a (
        .clk  (clk),
        .reset(reset_a),
        .out  (out_a)
    );

    counter #(.WIDTH(8), .RESET_VALUE(5), .STEP(3)) dut_b (
        .clk  (clk),
        .reset(reset_b),
        .out  (out_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    // Monitor: one output per rising edge, sampled at the following falling edge.
    always @(negedge clk) begin
        if (q_a.size() > 0) check("out_a", int'(out_a), q_a.pop_front());
        if (q_b.size() > 0) check("out_b", int'(out_b), q_b.pop_front());
    end

    // Hand-computed values after edges at 5,15,...,165 with reset pulses 17-28, 41-44 (between edges), 57-68.
    localparam int EXP_A[17] = '{1, 2, 0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

    task automatic reset_timeline_a();
        #17 reset_a = 1'b1;
        #11 reset_a = 1'b0;
        #13 reset_a = 1'b1;
        #3  reset_a = 1'b0;
        #13 reset_a = 1'b1;
        #11 reset_a = 1'b0;
    endtask

    task automatic stim_a();
        int e;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            q_a.push_back(EXP_A[i]);
        end
        // Reset held across three edges keeps the count at the reset value.
        @(negedge clk) reset_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            q_a.push_back(0);
        end
        @(negedge clk) reset_a = 1'b0;
        // 260 edges from 0: reaches 255 after 255 edges, then wraps or sticks.
        for (int k = 1; k <= 260; k++) begin
            @(posedge clk);
`ifdef COUNTER_SATURATE_EN
            e = (k > 255) ? 255 : k;
`else
            e = k % 256;
`endif
            q_a.push_back(e);
        end
        @(negedge clk) reset_a = 1'b1;
        @(posedge clk);
        q_a.push_back(0);
        @(negedge clk) reset_a = 1'b0;
        @(posedge clk);
        q_a.push_back(1);
    endtask

    task automatic stim_b();
        int e;
        // Reset high at edges 5 and 15.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            q_b.push_back(5);
        end
        @(negedge clk) reset_b = 1'b0;
        // 5, 8, 11, ... 254 (k=83), then 257 -> 1 wrapped or 255 saturated.
        for (int k = 1; k <= 86; k++) begin
            @(posedge clk);
            if (5 + 3 * k <= 255) e = 5 + 3 * k;
`ifdef COUNTER_SATURATE_EN
            else e = 255;
`else
            else e = (5 + 3 * k) % 256;
`endif
            q_b.push_back(e);
        end
        // Reset wins over increment, then counting resumes from 5.
        @(negedge clk) reset_b = 1'b1;
        @(posedge clk);
        q_b.push_back(5);
        @(negedge clk) reset_b = 1'b0;
        @(posedge clk);
        q_b.push_back(8);
        @(posedge clk);
        q_b.push_back(11);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("powerup_a", int'(out_a), 0);
        check("powerup_b", int'(out_b), 5);
        fork
            reset_timeline_a();
            stim_a();
            stim_b();
        join
        repeat (3) @(negedge clk);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
